// File: rtl/led_blink_scheduler.sv
// led_blink_scheduler
// Shares the single board LED between NUM_REQ pattern requesters. A grant is
// made round-robin from IDLE; the granted PATTERN_W-bit pattern is shifted out
// MSB first, one bit per prescaler tick.
// Build option: define LED_BLINK_SCHED_GAP_EN to add one dark tick period
// (GAP state) after each pattern before done is pulsed. Without it, done
// pulses on the tick that ends the last bit and the FSM returns to IDLE.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | LED dark, waiting for any req_valid; grants on the next edge
// PLAY  | shifting the latched pattern out, one bit per tick
// GAP   | LED dark for one tick period, then done and back to IDLE

module led_blink_scheduler #(
    parameter int CLK_HZ    = 30_000_000,
    parameter int TICK_HZ   = 10,
    parameter int NUM_REQ   = 4,
    parameter int PATTERN_W = 16
) (
    input  logic                         clk_30mhz,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*PATTERN_W-1:0] req_pattern,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         led,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         done
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = $clog2(DIV);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(PATTERN_W - 1);
    localparam logic [ID_W-1:0]  PTR_INIT = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1
`ifdef LED_BLINK_SCHED_GAP_EN
        ,
        GAP  = 2'd2
`endif
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [PRE_W-1:0]     pre_cnt;
    logic                 tick;
    logic                 armed_q;
    logic                 take;

    logic [PATTERN_W-1:0] shift_q;
    logic [PATTERN_W-1:0] shift_next;
    logic [PATTERN_W-1:0] shifted;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     bit_cnt_next;
    logic                 led_q;
    logic                 led_next;
    logic                 done_q;
    logic                 done_next;
    logic [NUM_REQ-1:0]   ready_q;
    logic [NUM_REQ-1:0]   ready_next;
    logic [ID_W-1:0]      grant_q;
    logic [ID_W-1:0]      grant_next;
    logic [ID_W-1:0]      ptr_q;
    logic [ID_W-1:0]      ptr_next;

    logic                 hi_found;
    logic                 lo_found;
    logic [ID_W-1:0]      hi_id;
    logic [ID_W-1:0]      lo_id;
    logic [PATTERN_W-1:0] hi_pat;
    logic [PATTERN_W-1:0] lo_pat;
    logic                 sel_found;
    logic [ID_W-1:0]      sel_id;
    logic [PATTERN_W-1:0] sel_pattern;

    assign tick    = (pre_cnt == PRE_LAST);
    assign shifted = shift_q << 1;

    // Round-robin pick: lowest valid index above the pointer wins, otherwise
    // the lowest valid index at or below it (the wrap-around half).
    always_comb begin
        hi_found = 1'b0;
        hi_id    = '0;
        hi_pat   = '0;
        lo_found = 1'b0;
        lo_id    = '0;
        lo_pat   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (i > int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_id    = ID_W'(i);
                    hi_pat   = req_pattern[i*PATTERN_W +: PATTERN_W];
                end else begin
                    lo_found = 1'b1;
                    lo_id    = ID_W'(i);
                    lo_pat   = req_pattern[i*PATTERN_W +: PATTERN_W];
                end
            end
        end
        sel_found   = hi_found | lo_found;
        sel_id      = hi_found ? hi_id  : lo_id;
        sel_pattern = hi_found ? hi_pat : lo_pat;
    end

    // Tick prescaler; restarted on every grant so bit 0 gets a full period.
    always_ff @(posedge clk_30mhz or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (take || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Blocks grants in the first cycle after reset release.
    always_ff @(posedge clk_30mhz or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_30mhz or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-output logic for the playback FSM.
    always_comb begin
        state_next   = state;
        take         = 1'b0;
        shift_next   = shift_q;
        bit_cnt_next = bit_cnt;
        led_next     = led_q;
        done_next    = 1'b0;
        ready_next   = '0;
        grant_next   = grant_q;
        ptr_next     = ptr_q;

        case (state)
            IDLE: begin
                led_next = 1'b0;
                if (armed_q && sel_found) begin
                    take         = 1'b1;
                    shift_next   = sel_pattern;
                    bit_cnt_next = '0;
                    led_next     = sel_pattern[PATTERN_W-1];
                    ready_next   = NUM_REQ'(1) << sel_id;
                    grant_next   = sel_id;
                    ptr_next     = sel_id;
                    state_next   = PLAY;
                end
            end

            PLAY: begin
                if (tick) begin
                    if (bit_cnt == BIT_LAST) begin
                        led_next = 1'b0;
`ifdef LED_BLINK_SCHED_GAP_EN
                        state_next = GAP;
`else
                        done_next  = 1'b1;
                        state_next = IDLE;
`endif
                    end else begin
                        shift_next   = shifted;
                        led_next     = shifted[PATTERN_W-1];
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end

`ifdef LED_BLINK_SCHED_GAP_EN
            GAP: begin
                led_next = 1'b0;
                if (tick) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
`endif

            default: begin
                led_next   = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // Pattern datapath and registered outputs.
    always_ff @(posedge clk_30mhz or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bit_cnt <= '0;
            led_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= '0;
            grant_q <= '0;
            ptr_q   <= PTR_INIT;
        end else begin
            shift_q <= shift_next;
            bit_cnt <= bit_cnt_next;
            led_q   <= led_next;
            done_q  <= done_next;
            ready_q <= ready_next;
            grant_q <= grant_next;
            ptr_q   <= ptr_next;
        end
    end

    assign led       = led_q;
    assign done      = done_q;
    assign req_ready = ready_q;
    assign grant_id  = grant_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Testbench for led_blink_scheduler at a scaled clock (CLK_HZ=100, TICK_HZ=10).
// A reference model tracks "time since grant" for the playing pattern and
// predicts every output each cycle; directed scenarios add explicit checks.
// Handles builds with or without LED_BLINK_SCHED_GAP_EN.

module tb_led_blink_scheduler;

    localparam int CLK_HZ    = 100;
    localparam int TICK_HZ   = 10;
    localparam int NUM_REQ   = 4;
    localparam int PATTERN_W = 16;
    localparam int DIV       = CLK_HZ / TICK_HZ;
`ifdef LED_BLINK_SCHED_GAP_EN
    localparam int GAP_TICKS = 1;
`else
    localparam int GAP_TICKS = 0;
`endif
    localparam int PLAY_CYC  = PATTERN_W * DIV;
    localparam int TOTAL     = PLAY_CYC + GAP_TICKS * DIV;

    logic                         clk_30mhz = 1'b0;
    logic                         rst_n     = 1'b1;
    logic [NUM_REQ-1:0]           req_valid = '0;
    logic [NUM_REQ*PATTERN_W-1:0] req_pattern = '0;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         led;
    logic                         busy;
    logic [1:0]                   grant_id;
    logic                         done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_count = 0;
    logic [NUM_REQ-1:0] ready_acc = '0;
    bit chk_en = 1'b0;

    // reference model state
    bit             m_active = 1'b0;
    int             m_t = 0;
    logic [15:0]    m_pat = '0;
    int             m_ptr = NUM_REQ - 1;
    int             m_gid = 0;
    bit             m_armed = 1'b0;
    logic [3:0]     m_ready = '0;
    bit             m_done = 1'b0;
    bit             m_found;
    int             m_c;

    led_blink_scheduler #(
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .NUM_REQ  (NUM_REQ),
        .PATTERN_W(PATTERN_W)
    ) dut (
        .clk_30mhz  (clk_30mhz),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_pattern(req_pattern),
        .req_ready  (req_ready),
        .led        (led),
        .busy       (busy),
        .grant_id   (grant_id),
        .done       (done)
    );

    always #5 clk_30mhz = ~clk_30mhz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: a granted pattern occupies TOTAL cycles; done marks its end.
    always @(posedge clk_30mhz) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_t      = 0;
            m_pat    = '0;
            m_ptr    = NUM_REQ - 1;
            m_gid    = 0;
            m_armed  = 1'b0;
            m_ready  = '0;
            m_done   = 1'b0;
        end else begin
            m_ready = '0;
            m_done  = 1'b0;
            if (m_active) begin
                m_t++;
                if (m_t == TOTAL) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end else if (m_armed && req_valid != '0) begin
                m_found = 1'b0;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    m_c = (m_ptr + k) % NUM_REQ;
                    if (!m_found && req_valid[m_c]) begin
                        m_found = 1'b1;
                        m_gid   = m_c;
                    end
                end
                m_ptr    = m_gid;
                m_pat    = req_pattern[m_gid*PATTERN_W +: PATTERN_W];
                m_ready  = 4'(1 << m_gid);
                m_active = 1'b1;
                m_t      = 0;
            end
            m_armed = 1'b1;
        end
    end

    function automatic logic exp_led();
        if (m_active && m_t < PLAY_CYC) return m_pat[PATTERN_W-1 - m_t/DIV];
        return 1'b0;
    endfunction

    always @(negedge clk_30mhz) begin
        if (chk_en && rst_n) begin
            check("m_led",   32'(led),       32'(exp_led()));
            check("m_busy",  32'(busy),      32'(m_active));
            check("m_done",  32'(done),      32'(m_done));
            check("m_ready", 32'(req_ready), 32'(m_ready));
            check("m_grant", 32'(grant_id),  32'(m_gid));
        end
    end

    task automatic step();
        @(negedge clk_30mhz);
        #1;
        cyc++;
        if (done) done_count++;
        ready_acc = ready_acc | req_ready;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        #1;
        check("rst_led",   32'(led),       32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_grant", 32'(grant_id),  32'd0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input int idx, input int budget);
        bit got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            step();
            if (req_ready != '0) begin
                got = 1'b1;
                check("grant_ready", 32'(req_ready), 32'(1) << idx);
                check("grant_id",    32'(grant_id),  32'(idx));
                req_valid[idx] = 1'b0;
            end
        end
        check("grant_seen", 32'(got), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        bit got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            step();
            if (!busy) got = 1'b1;
        end
        check("idle_seen", 32'(got), 32'd1);
    endtask

    // Call in the cycle right after the grant edge; leaves t = PLAY_CYC.
    task automatic play_check(input logic [15:0] pat);
        for (int b = 0; b < PATTERN_W; b++) begin
            for (int c = 0; c < DIV; c++) begin
                check("led_seq", 32'(led), 32'(pat[PATTERN_W-1-b]));
                step();
            end
        end
    endtask

    logic [15:0] pat_a;
    logic [15:0] pat_s;
    logic [15:0] pat_1;
    logic        led_hist[PLAY_CYC];
    int          got_ids[$];
    int          done_cyc;
    int          id;
    int          cnt;
    int          low;
    int          done_off;

    initial begin
        // Single request on req 2, held through reset release
        pat_a = 16'hA5F0;
        req_pattern[2*PATTERN_W +: PATTERN_W] = pat_a;
        req_valid = 4'b0100;
        do_reset();
        chk_en = 1'b1;
        step();
        check("no_grant_first", 32'(req_ready), 32'd0);
        check("no_busy_first",  32'(busy),      32'd0);
        wait_grant(2, 5);
        play_check(pat_a);
        for (int c = 0; c < GAP_TICKS * DIV; c++) begin
            check("gap_led",  32'(led),  32'd0);
            check("gap_done", 32'(done), 32'd0);
            step();
        end
        check("done_pulse", 32'(done), 32'd1);
        step();
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);

        // All four requesters continuously valid
        do_reset();
        for (int i = 0; i < NUM_REQ; i++)
            req_pattern[i*PATTERN_W +: PATTERN_W] = {4'(i + 1), 12'($urandom)};
        req_valid = 4'b1111;
        done_cyc = -1;
        for (int n = 0; n < 6 * TOTAL && got_ids.size() < 5; n++) begin
            step();
            if (done) done_cyc = cyc;
            if (req_ready != '0) begin
                id = 0;
                for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) id = i;
                if (got_ids.size() > 0) check("rr_gap", 32'(cyc - done_cyc), 32'd1);
                got_ids.push_back(id);
            end
        end
        check("rr_count", 32'(got_ids.size()), 32'd5);
        for (int i = 0; i < got_ids.size(); i++)
            check("rr_order", 32'(got_ids[i]), 32'(i % NUM_REQ));
        req_valid = '0;
        wait_idle(2 * TOTAL);

        // Pattern change and withdrawal while req 0 plays
        pat_s = 16'($urandom) | 16'h8001;
        req_pattern[0 +: PATTERN_W] = pat_s;
        req_valid = 4'b0001;
        wait_grant(0, 5);
        ready_acc = '0;
        req_valid[1] = 1'b1;
        req_pattern[PATTERN_W +: PATTERN_W] = 16'($urandom);
        for (int i = 0; i < PLAY_CYC; i++) begin
            led_hist[i] = led;
            if (i == 30) begin
                req_pattern[0 +: PATTERN_W] = ~pat_s;
                req_valid[1] = 1'b0;
            end
            step();
        end
        wait_idle(2 * TOTAL);
        run(5);
        check("withdraw_no_ack", 32'(ready_acc[1]), 32'd0);
        for (int b = 0; b < PATTERN_W; b++)
            check("latched_pattern", 32'(led_hist[b*DIV + DIV/2]), 32'(pat_s[PATTERN_W-1-b]));

        // Reset during bit 7, then a fresh grant
        req_pattern[3*PATTERN_W +: PATTERN_W] = 16'($urandom) | 16'hFF00;
        req_valid = 4'b1000;
        wait_grant(3, 5);
        run(7 * DIV + 3);
        do_reset();
        done_count = 0;
        run(TOTAL);
        check("abort_no_done", 32'(done_count), 32'd0);
        pat_1 = 16'($urandom);
        req_pattern[PATTERN_W +: PATTERN_W] = pat_1;
        req_valid = 4'b0010;
        wait_grant(1, 5);
        play_check(pat_1);
        wait_idle(2 * TOTAL);

        // Two all-ones patterns back to back (req 0 then req 1)
        req_pattern[0 +: PATTERN_W] = 16'hFFFF;
        req_pattern[PATTERN_W +: PATTERN_W] = 16'hFFFF;
        req_valid = 4'b0011;
        wait_grant(0, 5);
        cnt = 0;
        while (led && cnt < 400) begin
            cnt++;
            step();
        end
        check("ffff_run0", 32'(cnt), 32'(PLAY_CYC));
        low = 0;
        done_off = -1;
        while (!led && low < 400) begin
            if (done && done_off < 0) done_off = low;
            low++;
            step();
        end
        if (req_ready[1]) req_valid[1] = 1'b0;
        check("ffff_gap", 32'(low), 32'(GAP_TICKS * DIV + 1));
        check("done_at_last_tick", 32'(done_off), 32'(GAP_TICKS * DIV));
        check("ffff_second_id", 32'(grant_id), 32'd1);
        cnt = 0;
        while (led && cnt < 400) begin
            cnt++;
            step();
        end
        check("ffff_run1", 32'(cnt), 32'(PLAY_CYC));
        req_valid = '0;
        wait_idle(2 * TOTAL);

        // Randomized requests, withdrawals and pattern changes
        for (int n = 0; n < 3000; n++) begin
            req_valid = req_valid & ~req_ready;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && $urandom_range(15) == 0) begin
                    req_pattern[i*PATTERN_W +: PATTERN_W] =
                        ($urandom_range(7) == 0) ? 16'h0000 : 16'($urandom);
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && $urandom_range(199) == 0) begin
                    req_valid[i] = 1'b0;
                end else if ($urandom_range(49) == 0) begin
                    req_pattern[i*PATTERN_W +: PATTERN_W] = 16'($urandom);
                end
            end
            step();
        end
        req_valid = '0;
        wait_idle(2 * TOTAL);
        run(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/led_blink_scheduler.md
# led_blink_scheduler

Round-robin scheduler that shares the single board LED between several pattern requesters, such as web-command, heartbeat and error sources. It contains its own tick prescaler, derived from the 30 MHz system clock, and plays one granted 16-bit blink pattern at a time, one bit per tick. A short dark gap separates consecutive patterns. It sits between the command decoders and the LED pin, replacing a free-running fixed-rate blinker.

## Interface
- CLK_HZ, 30_000_000, input clock frequency in Hz
- TICK_HZ, 10, pattern bit rate in Hz; CLK_HZ/TICK_HZ must be an integer ≥ 2
- NUM_REQ, 4, number of requesters (2..8)
- PATTERN_W, 16, bits per pattern

Ports:
- clk_30mhz  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  NUM_REQ  per-requester request; held until accepted
- req_pattern  in  NUM_REQ*PATTERN_W  pattern of requester i in bits [i*PATTERN_W +: PATTERN_W]
- req_ready  out  NUM_REQ  one-hot, one-cycle acceptance pulse
- led  out  1  LED drive, active-high
- busy  out  1  high whenever state ≠ IDLE
- grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester
- done  out  1  one-cycle pulse when a pattern (and its gap) completes

## Operation
- Reset values:
  - state = IDLE
  - led, busy, done, req_ready all 0
  - grant_id = 0
  - prescaler = 0
  - round-robin pointer = NUM_REQ-1, so requester 0 has first priority
- Prescaler:
  - Counts 0..CLK_HZ/TICK_HZ-1 and wraps.
  - tick is an internal one-cycle pulse at the terminal count.
  - Cleared to 0 on every grant, so each pattern bit lasts exactly CLK_HZ/TICK_HZ cycles.
- FSM states: IDLE, PLAY, GAP.
- IDLE:
  - If any req_valid is high, select the first set bit searching upward from pointer+1, with wrap.
  - At that edge:
    - latch its pattern into the shift register;
    - set req_ready[i] for one cycle;
    - set grant_id=i and pointer=i;
    - set led = pattern[PATTERN_W-1];
    - clear the bit counter and the prescaler;
    - go to PLAY.
- PLAY:
  - On each tick: shift left, drive led from the new MSB, increment the bit counter.
  - On the tick that ends bit PATTERN_W-1, go to GAP and set led=0.
- GAP:
  - led=0 for one full tick period.
  - On tick: pulse done and go to IDLE.
- Requests arriving during PLAY/GAP wait. req_valid still high in the IDLE cycle after done is treated as a new request.
- req_valid dropped before acceptance is a withdrawal; no grant is made.
- req_pattern is sampled only on the grant edge; later changes have no effect on the playing pattern.
- An all-zero pattern still plays for its full duration with the LED dark.

## Timing
- Grant latency: req_valid high before edge k (state IDLE) → req_ready and led valid after edge k.
- Pattern duration: PATTERN_W × CLK_HZ/TICK_HZ cycles, then the gap adds 1 × CLK_HZ/TICK_HZ.
- done is high for exactly one cycle, coincident with the return to IDLE.
- Earliest next grant is the edge after done, so back-to-back requesters see one IDLE cycle between patterns.
- All requesters asserted continuously are granted in order 0,1,2,3,0,…; no requester is granted twice while another is pending.
- rst_n low at any time, including mid-PLAY: outputs return to reset values immediately and the partial pattern is discarded with no done pulse.
- Release of rst_n is synchronised by the system; the block makes no grant in the first cycle after release.

## Configuration
- LED_BLINK_SCHED_GAP_EN:
  - Defined: GAP state present as above.
  - Undefined: GAP state is removed. PLAY goes straight to IDLE on the tick ending the last bit, with done pulsed on that edge, and patterns run back to back with only the one IDLE cycle between them.

## Test plan
- Scaled bench CLK_HZ=100, TICK_HZ=10; reset mid-run:
  - Check led=0, busy=0, done=0, req_ready=0, grant_id=0 asynchronously on rst_n fall.
  - Check no grant in the first cycle after release.
- Single request, pattern 16'hA5F0 on req 2:
  - req_ready=4'b0100 for one cycle, grant_id=2.
  - led follows 1,0,1,0,0,1,0,1,1,1,1,1,0,0,0,0, each for 10 cycles.
  - Then 10 cycles dark (GAP_EN), then done for 1 cycle.
- All four requesters valid continuously with distinct patterns:
  - Grants in order 0,1,2,3,0.
  - Each grant follows the previous done by exactly one cycle.
- req_pattern changed and req 1 withdrawn during PLAY of req 0:
  - Playing pattern is unchanged.
  - Req 1 is never acknowledged.
- rst_n pulse at bit 7 of a pattern: no done, led=0, and the next request is granted with a fresh full pattern.
- Build without LED_BLINK_SCHED_GAP_EN:
  - Pattern 16'hFFFF from req 0 then req 1: led stays 1 for 160 cycles per pattern, low only in the single IDLE cycle between them.
  - done asserts on the last-bit tick.
